// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          CLK100MHZ,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_busy,
    output logic                          wr_overflow,
    output logic                          uart_rxd_out
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               line_q, line_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic               bit_end;
    logic               fifo_empty;
    logic               pop;
    logic               wr_accept;

    always_ff @(posedge CLK100MHZ) begin
        if (wr_accept) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_comb begin
        bit_end    = (cnt_q == CNT_LAST);
        fifo_empty = (count_q == '0);
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when more bytes are queued.
                if (bit_end) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (pop) begin
            shift_d = mem_q[rptr_q];
        end
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        parity_d = parity_q;
        if (pop) begin
            parity_d = ^mem_q[rptr_q];
        end
    end
`endif

    always_comb begin
        wr_accept = wr_en && (!full_q || pop);
        wptr_d    = wptr_q + PTR_W'(wr_accept);
        rptr_d    = rptr_q + PTR_W'(pop);
        count_d   = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == LVL_FULL);
        ovf_d  = wr_en && !wr_accept;
        // Current state also counts so busy drops in step with the last stop-bit line cycle.
        busy_d = (state_q != S_IDLE) || (state_d != S_IDLE) || (count_d != '0);

        line_d = 1'b1;
        case (state_q)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_d = parity_q;
`endif
            default:  line_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            line_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            line_q   <= line_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign fifo_full    = full_q;
    assign fifo_level   = count_q;
    assign tx_busy      = busy_q;
    assign wr_overflow  = ovf_q;
    assign uart_rxd_out = line_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx, run at 16 clocks per bit; a passive line
// receiver decodes every frame into a queue for byte and timing checks.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       fifo_full;
    logic [3:0] fifo_level;
    logic       tx_busy;
    logic       wr_overflow;
    logic       uart_rxd_out;

    uart_tx #(
        .CLK_FREQ   (1600000),
        .BAUD       (100000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK100MHZ    (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_full    (fifo_full),
        .fifo_level   (fifo_level),
        .tx_busy      (tx_busy),
        .wr_overflow  (wr_overflow),
        .uart_rxd_out (uart_rxd_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Passive receiver: mid-bit sampling, frames cut by reset are discarded.
    logic [7:0]  rx_q[$];
    int unsigned rx_cyc_q[$];
    bit          rx_err_q[$];

    task automatic mon_wait(input int unsigned n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (reset !== 1'b0) ab = 1'b1;
        end
    endtask

    always begin : rx_mon
        logic [7:0]  b;
        bit          ab;
        bit          bad;
        int unsigned st;
        @(negedge clk);
        if (reset === 1'b0 && uart_rxd_out === 1'b0) begin
            st  = cyc;
            ab  = 1'b0;
            bad = 1'b0;
            b   = '0;
            mon_wait(CPB / 2, ab);
            if (uart_rxd_out !== 1'b0) bad = 1'b1;
            for (int i = 0; i < 8; i++) begin
                mon_wait(CPB, ab);
                b[i] = uart_rxd_out;
            end
`ifdef UART_TX_PARITY_EN
            mon_wait(CPB, ab);
            if (uart_rxd_out !== ^b) bad = 1'b1;
`endif
            mon_wait(CPB, ab);
            if (uart_rxd_out !== 1'b1) bad = 1'b1;
            if (!ab) begin
                rx_q.push_back(b);
                rx_cyc_q.push_back(st);
                rx_err_q.push_back(bad);
            end
        end
    end

    // Called on the first start-bit sample; checks every sample of the frame.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic [NBITS-1:0] fr;
        bit               ok;
        logic             seen;
`ifdef UART_TX_PARITY_EN
        fr = {1'b1, ^b, b, 1'b0};
`else
        fr = {1'b1, b, 1'b0};
`endif
        for (int unsigned k = 0; k < NBITS; k++) begin
            ok   = 1'b1;
            seen = fr[k];
            for (int unsigned s = 0; s < CPB; s++) begin
                if (uart_rxd_out !== fr[k]) begin
                    ok   = 1'b0;
                    seen = uart_rxd_out;
                end
                if (!(k == NBITS - 1 && s == CPB - 1)) @(negedge clk);
            end
            check($sformatf("%s bit%0d held", tag, k), {31'd0, ok}, 32'd1);
            check($sformatf("%s bit%0d level", tag, k), {31'd0, seen}, {31'd0, fr[k]});
        end
    endtask

    task automatic send_exact(input logic [7:0] b, input string tag);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
        check({tag, " level after write"}, fifo_level, 1);
        check({tag, " busy after write"}, tx_busy, 1);
        check({tag, " line idle after write"}, uart_rxd_out, 1);
        @(negedge clk);
        check({tag, " level after pop"}, fifo_level, 0);
        check({tag, " line high at pop"}, uart_rxd_out, 1);
        @(negedge clk);
        expect_frame(b, tag);
        check({tag, " busy last cycle"}, tx_busy, 1);
        @(negedge clk);
        check({tag, " busy cleared"}, tx_busy, 0);
        check({tag, " line idle after"}, uart_rxd_out, 1);
    endtask

    task automatic wait_rx(input int unsigned n, input int unsigned limit, input string tag);
        int unsigned t = 0;
        while (rx_q.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        check({tag, " rx count"}, rx_q.size(), n);
    endtask

    task automatic wait_idle(input int unsigned limit, input string tag);
        int unsigned t = 0;
        while (tx_busy !== 1'b0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        check({tag, " idle"}, tx_busy, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned base;
        int unsigned n0;
        int unsigned target;
        bit          stay_high;
        logic [7:0]  exp_b;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst line", uart_rxd_out, 1);
        check("rst full", fifo_full, 0);
        check("rst level", fifo_level, 0);
        check("rst busy", tx_busy, 0);
        check("rst ovf", wr_overflow, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single byte, exact latency and waveform
        send_exact(8'h55, "t1");
        wait_rx(1, 2 * FRAME, "t1");
        check("t1 byte", rx_q[0], 8'h55);
        check("t1 frame err", rx_err_q[0], 0);

        // Back-to-back writes, frames chained without gap
        base    = rx_q.size();
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk);
        wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        wait_rx(base + 2, 3 * FRAME, "t2");
        check("t2 byte0", rx_q[base], 8'hA5);
        check("t2 byte1", rx_q[base + 1], 8'h3C);
        check("t2 start gap", rx_cyc_q[base + 1] - rx_cyc_q[base], FRAME);
        check("t2 frame err", {31'd0, rx_err_q[base] | rx_err_q[base + 1]}, 0);
        wait_idle(2 * FRAME, "t2");
        @(negedge clk);

        // Fill FIFO, overflow on the tenth write
        base = rx_q.size();
        n0   = 0;
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            @(negedge clk);
            if (i == 0) n0 = cyc;
            check($sformatf("t3 ovf w%0d", i), wr_overflow, (i == 9) ? 1 : 0);
            if (i == 8) begin
                check("t3 full at 8", fifo_full, 1);
                check("t3 level at 8", fifo_level, DEPTH);
            end
        end
        wr_en = 1'b0;
        check("t3 level after drop", fifo_level, DEPTH);
        @(negedge clk);
        check("t3 ovf pulse end", wr_overflow, 0);

        // Write into full FIFO on the stop-bit pop edge
        target = n0 + 1 + FRAME;
        while (cyc < target - 1) @(negedge clk);
        check("t4 level before pop", fifo_level, DEPTH);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        check("t4 level", fifo_level, DEPTH);
        check("t4 full", fifo_full, 1);
        check("t4 ovf", wr_overflow, 0);
        wait_rx(base + 10, 12 * FRAME, "t3");
        for (int unsigned k = 0; k < 10; k++) begin
            exp_b = (k == 9) ? 8'hEE : 8'(k);
            check($sformatf("t3 byte%0d", k), rx_q[base + k], exp_b);
            check($sformatf("t3 err%0d", k), rx_err_q[base + k], 0);
        end
        wait_idle(2 * FRAME, "t3");
        @(negedge clk);

        // Reset in the middle of a frame with bytes queued
        base = rx_q.size();
        wr_en = 1'b1;
        foreach (rx_err_q[k]) begin end
        wr_data = 8'hFF; @(negedge clk);
        wr_data = 8'h11; @(negedge clk);
        wr_data = 8'h22; @(negedge clk);
        wr_data = 8'h33; @(negedge clk);
        wr_data = 8'h44; @(negedge clk);
        wr_en = 1'b0;
        repeat (3 * CPB + 7) @(negedge clk);
        check("t5 level pre-reset", fifo_level, 4);
        #2 reset = 1'b1;
        #1;
        check("t5 rst line", uart_rxd_out, 1);
        check("t5 rst busy", tx_busy, 0);
        check("t5 rst level", fifo_level, 0);
        check("t5 rst full", fifo_full, 0);
        repeat (3) @(negedge clk);
        check("t5 rst line held", uart_rxd_out, 1);
        reset = 1'b0;
        stay_high = 1'b1;
        repeat (4 * FRAME) begin
            @(negedge clk);
            if (uart_rxd_out !== 1'b1 || tx_busy !== 1'b0) stay_high = 1'b0;
        end
        check("t5 quiet after reset", {31'd0, stay_high}, 1);
        check("t5 no frames", rx_q.size(), base);
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        wait_rx(base + 1, 3 * FRAME, "t5");
        check("t5 byte", rx_q[base], 8'h5A);
        wait_idle(2 * FRAME, "t5");
        @(negedge clk);

        // Parity-sensitive bytes (odd and even popcount)
        send_exact(8'h07, "t6a");
        @(negedge clk);
        send_exact(8'h03, "t6b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Memory-mapped UART transmitter; the outbound counterpart to the board's serial receive path (uart_txd_in).
- The CPU's load/store unit writes bytes through a single-beat write strobe into a small FIFO.
- The block serialises each byte as 8N1, LSB first, on uart_rxd_out.
- Status outputs (busy, full, level) are read back by the CPU through the same MMIO window.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s
CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 868 at defaults), cycles per line bit; must be >= 4
FIFO_DEPTH, 8, byte entries; power of two, 2..64

Ports:
CLK100MHZ  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
wr_en  input  1  single-cycle write strobe from MMIO store decode
wr_data  input  8  byte to transmit, sampled when wr_en=1
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently queued (excludes the byte in the shifter)
tx_busy  output  1  shifter active or FIFO non-empty
wr_overflow  output  1  one-cycle pulse: a write was dropped
uart_rxd_out  output  1  serial line to host, idle high, registered

Behaviour:
- Reset (async assert, sync release by design use):
  - uart_rxd_out=1; fifo_full=0; fifo_level=0; tx_busy=0; wr_overflow=0.
  - State=IDLE; baud counter=0; bit index=0; FIFO pointers=0.
  - Reset mid-frame aborts the frame immediately: the line returns high in the same reset assertion and queued bytes are discarded.
- FIFO:
  - Circular buffer. Write pointer advances on an accepted write; read pointer advances on a pop. Both wrap modulo FIFO_DEPTH.
  - Write accepted iff wr_en=1 and (not full, or a pop happens in the same cycle).
  - Write to a full FIFO with no same-cycle pop: data dropped, wr_overflow=1 for exactly that cycle, pointers unchanged.
  - Simultaneous write and pop: level unchanged, both pointers advance.
- State machine (one baud counter counts 0..CLKS_PER_BIT-1; a bit ends when the counter hits CLKS_PER_BIT-1):
  - IDLE: line=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the counter, go to START.
  - START: line=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: line=shift[0] for CLKS_PER_BIT cycles; then shift right, increment the index. After index 7 completes, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles. At the end: if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency:
  - wr_en accepted at edge N into an empty FIFO with the block idle: pop at edge N+1, uart_rxd_out falls after edge N+2.
  - Frame length exactly 10*CLKS_PER_BIT cycles (8680 at defaults).
- Outputs:
  - fifo_level and fifo_full reflect state after each edge (registered).
  - tx_busy=1 from the edge a write is accepted until the stop bit's final cycle completes with the FIFO empty.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles (8E1).
- Undefined: no PARITY state, no parity logic synthesised; frame = 10*CLKS_PER_BIT (8N1).

Test Plan:
- Reset, then write 0x55 once → line low at cycle 2 for 868 cycles; data bits 1,0,1,0,1,0,1,0 at 868 cycles each; high stop bit; tx_busy falls after cycle 2+8680; fifo_level 1→0 at cycle 1.
- Back-to-back writes 0xA5 then 0x3C on consecutive cycles → two frames with the second start bit beginning exactly 8680 cycles after the first; decoded bytes 0xA5, 0x3C.
- With the line idle, write 10 bytes 0x00..0x09 on consecutive cycles → 1st popped into shifter, 2nd–9th fill FIFO (fifo_full=1, fifo_level=8), 10th dropped with a single wr_overflow pulse; 9 frames transmitted, 0x09 never appears.
- Full FIFO with a write coinciding with the pop at the end of a STOP bit → write accepted, no overflow pulse, fifo_level stays 8.
- Assert reset 3000 cycles into a 0xFF frame with 4 bytes queued → uart_rxd_out=1, tx_busy=0, fifo_level=0 during reset; nothing transmitted after release until a new write.
- UART_TX_PARITY_EN defined, write 0x07 → parity bit 1 after the 8 data bits, then stop; frame 9548 cycles; write 0x03 → parity bit 0.
